i2c_sensor_reader: RTL and testbench
====================================

Name: i2c_sensor_reader

Overview:
- Upstream transaction sequencer that drives the i2c_master command interface (ena/addr/rw/data_wr) and consumes busy/data_rd/ack_error.
- Performs an energy-sensor register read: one write of the register pointer, a repeated start, then a 2-byte read (MSB first).
- Returns a 16-bit sample with a one-cycle valid pulse.
- Triggers periodically or on demand; feeds the energy-supervision datapath.

Parameters:
- SLAVE_ADDR, 7'h40, 7-bit I2C address of the sensor.
- REG_PTR, 8'h02, register pointer written before each read.
- PERIOD_CYCLES, 1000000, clk cycles between auto-triggered reads; minimum 2.
- TIMEOUT_CYCLES, 200000, maximum clk cycles spent in any one wait state before abort.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- trigger  in  1  single-cycle request for one read; ignored unless state is IDLE.
- auto_en  in  1  1 = periodic reads every PERIOD_CYCLES.
- i2c_ena  out  1  to master ena.
- i2c_addr  out  7  to master addr; constant SLAVE_ADDR.
- i2c_rw  out  1  to master rw.
- i2c_data_wr  out  8  to master data_wr; constant REG_PTR.
- i2c_busy  in  1  from master busy.
- i2c_data_rd  in  8  from master data_rd.
- i2c_ack_error  in  1  from master ack_error.
- sample  out  16  last good sample {MSB, LSB}; held until the next good read.
- sample_valid  out  1  one-cycle pulse when sample updates.
- error  out  1  set on NACK or timeout; cleared on the next good sample.
- active  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: i2c_ena=0, i2c_rw=0, sample=0, sample_valid=0, error=0, active=0. Internal: state=IDLE, period counter=0, timeout counter=0.
- i2c_busy is registered once. busy_rise and busy_fall are single-cycle edge detects on that registered copy.
- Period counter runs while auto_en=1. At PERIOD_CYCLES-1 it wraps to 0 and raises a pending request. With auto_en=0 it is cleared to 0.
- In IDLE, a pending request or trigger starts a read. A trigger arriving outside IDLE is dropped. A period wrap outside IDLE sets pending, which is serviced at the next IDLE; pending is one bit and does not count.
- States:
  - IDLE: on start request go to WAIT_FREE.
  - WAIT_FREE: wait for i2c_busy=0. This covers the master's post-reset busy=1. Then assert i2c_ena=1, i2c_rw=0 and go to PTR.
  - PTR: on busy_rise (pointer write latched by master), set i2c_rw=1 and go to RD_MSB.
  - RD_MSB: on busy_rise (first read latched), go to RD_LSB.
  - RD_LSB: on busy_rise (second read latched), capture i2c_data_rd as MSB, drive i2c_ena=0, go to FINISH.
  - FINISH: on busy_fall, capture i2c_data_rd as LSB, go to CHECK.
  - CHECK: if i2c_ack_error=1, set error, leave sample unchanged. Otherwise update sample, pulse sample_valid, clear error. Go to IDLE.
- Latency: sample_valid occurs 2 clk cycles after busy_fall in FINISH.
- Timeout: the timeout counter resets on every state change. In WAIT_FREE, PTR, RD_MSB, RD_LSB and FINISH, reaching TIMEOUT_CYCLES sets error, forces i2c_ena=0 and goes to IDLE. If the timeout fires in the same cycle as a valid edge, the edge takes priority.
- i2c_ack_error asserting mid-sequence does not abort. It is evaluated only in CHECK, because the master keeps it sticky for the whole transaction.
- Asynchronous reset mid-transaction returns every output to its reset value immediately. The master is reset by the same signal.

Optional Feature:
- Macro: SENSOR_READER_AVG4_EN.
- Defined:
  - Adds an 18-bit accumulator and a 2-bit sample counter.
  - Each good read adds its value to the accumulator.
  - sample and sample_valid update only on every 4th good read, with sample = acc[17:2], after which the accumulator clears.
  - A NACK or timeout clears both the accumulator and the counter.
- Undefined: every good read updates sample directly. No accumulator logic is synthesised.

Decomposition:
- Shared package i2c_pkg:
  - state encodings (IDLE..CHECK, 3 bits);
  - default sensor address 7'h40 and register-pointer constants (shunt 8'h01, bus 8'h02, power 8'h03);
  - the log2 width helper used for the counter widths.
- Sub-module edge_detect (registered input, rise/fall outputs), reusable by the other i2c blocks.
- Everything else stays in one module.

Test Plan:
- Slave model at address 0x40 returning 0x12, 0x34; trigger once with auto_en=0 -> exactly one pointer write of 0x02, a repeated start, two reads; sample=16'h1234, one sample_valid pulse, error=0.
- No slave (NACK): trigger -> error=1, sample keeps its previous value, no sample_valid, active=0 afterwards.
- i2c_busy stuck at 1: trigger -> error asserts after TIMEOUT_CYCLES+1 cycles in WAIT_FREE, i2c_ena never asserts, return to IDLE.
- PERIOD_CYCLES=5000, auto_en=1 -> a read starts every 5000 cycles; a trigger during an active read is dropped (transaction count unchanged).
- Assert reset while in RD_LSB -> i2c_ena=0, active=0 and sample=0 in the same cycle; after release, the next trigger completes a normal read.
- SENSOR_READER_AVG4_EN defined, slave returns 100, 200, 300, 400 -> one sample_valid only, after the 4th read, with sample=250.

Source files
------------

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C sensor blocks:
//   - state_t          : sequencer state encoding (3 bits)
//   - SENSOR_ADDR_DEF  : default 7-bit address of the energy sensor
//   - REG_SHUNT/BUS/POWER : sensor register-pointer values
//   - cnt_width()      : bits needed to count from 0 up to a given value
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FREE = 3'd1,
        ST_PTR       = 3'd2,
        ST_RD_MSB    = 3'd3,
        ST_RD_LSB    = 3'd4,
        ST_FINISH    = 3'd5,
        ST_CHECK     = 3'd6
    } state_t;

    localparam logic [6:0] SENSOR_ADDR_DEF = 7'h40;

    localparam logic [7:0] REG_SHUNT = 8'h01;
    localparam logic [7:0] REG_BUS   = 8'h02;
    localparam logic [7:0] REG_POWER = 8'h03;

    // Width of a counter that must hold every value in 0..max_val (at least 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/i2c_sensor_reader_edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Registers a single-bit input once and flags its rising/falling edges on the
// registered copy. Used for the i2c_master busy handshake.
// Ports:
//   clk   in  : system clock, rising edge
//   reset in  : asynchronous active-high reset
//   din   in  : raw input
//   level out : din registered once
//   rise  out : single-cycle pulse, registered copy went 0->1
//   fall  out : single-cycle pulse, registered copy went 1->0
// -----------------------------------------------------------------------------
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic din_p0;
    logic din_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_p0 <= 1'b0;
            din_p1 <= 1'b0;
        end else begin
            din_p0 <= din;
            din_p1 <= din_p0;
        end
    end

    assign level = din_p0;
    assign rise  = din_p0 & ~din_p1;
    assign fall  = ~din_p0 & din_p1;

endmodule

// File: rtl/i2c_sensor_reader.sv
// -----------------------------------------------------------------------------
// i2c_sensor_reader
// Sequences an energy-sensor register read through the i2c_master command
// interface: pointer write, repeated start, 2-byte read (MSB first). Returns a
// 16-bit sample with a one-cycle valid pulse. Reads start on trigger or
// every PERIOD_CYCLES while auto_en is high.
//
// Optional build macro SENSOR_READER_AVG4_EN: sample becomes the mean of every
// four good reads (18-bit accumulator, 2-bit read counter).
//
// Ports:
//   clk, reset            : clock (rising) / asynchronous active-high reset
//   trigger, auto_en      : on-demand request / periodic mode enable
//   i2c_ena, i2c_addr, i2c_rw, i2c_data_wr : commands to the master
//   i2c_busy, i2c_data_rd, i2c_ack_error   : status from the master
//   sample, sample_valid  : last good sample and its update pulse
//   error                 : NACK or timeout seen, cleared by a good read
//   active                : sequencer not idle
// -----------------------------------------------------------------------------
module i2c_sensor_reader
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR     = SENSOR_ADDR_DEF,
    parameter logic [7:0] REG_PTR        = REG_BUS,
    parameter int         PERIOD_CYCLES  = 1000000,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic        auto_en,
    output logic        i2c_ena,
    output logic [6:0]  i2c_addr,
    output logic        i2c_rw,
    output logic [7:0]  i2c_data_wr,
    input  logic        i2c_busy,
    input  logic [7:0]  i2c_data_rd,
    input  logic        i2c_ack_error,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        error,
    output logic        active
);

    localparam int PER_W = cnt_width(PERIOD_CYCLES - 1);
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    state_t            state;
    logic [PER_W-1:0]  per_cnt;
    logic              per_wrap;
    logic              pending;
    logic              start_req;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              in_wait;
    logic              edge_ok;
    logic              busy_q;
    logic              busy_rise;
    logic              busy_fall;
    logic [7:0]        msb_q;
    logic [7:0]        lsb_q;

`ifdef SENSOR_READER_AVG4_EN
    logic [17:0]       acc;
    logic [1:0]        avg_cnt;
    logic [17:0]       acc_sum;
    assign acc_sum = acc + {2'b00, msb_q, lsb_q};
`endif

    edge_detect u_busy_edge (
        .clk   (clk),
        .reset (reset),
        .din   (i2c_busy),
        .level (busy_q),
        .rise  (busy_rise),
        .fall  (busy_fall)
    );

    assign i2c_addr    = SLAVE_ADDR;
    assign i2c_data_wr = REG_PTR;
    assign active      = (state != ST_IDLE);

    // A wrap seen while idle starts the read directly; otherwise it is parked.
    assign per_wrap  = auto_en && (per_cnt == PER_LAST);
    assign start_req = trigger | pending | per_wrap;
    assign tmo_hit   = (tmo_cnt == TMO_LIMIT);
    assign in_wait   = (state != ST_IDLE) && (state != ST_CHECK);

    // The event each wait state is waiting for; it beats a simultaneous timeout.
    always_comb begin
        edge_ok = 1'b0;
        case (state)
            ST_WAIT_FREE:                  edge_ok = ~busy_q;
            ST_PTR, ST_RD_MSB, ST_RD_LSB:  edge_ok = busy_rise;
            ST_FINISH:                     edge_ok = busy_fall;
            default:                       edge_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt <= '0;
            pending <= 1'b0;
        end else begin
            if (!auto_en || per_wrap) per_cnt <= '0;
            else                      per_cnt <= per_cnt + 1'b1;

            if (state == ST_IDLE) pending <= 1'b0;
            else if (per_wrap)    pending <= 1'b1;
        end
    end

    // Byte capture: data path, no reset needed.
    always_ff @(posedge clk) begin
        if (state == ST_RD_LSB && busy_rise) msb_q <= i2c_data_rd;
        if (state == ST_FINISH && busy_fall) lsb_q <= i2c_data_rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            tmo_cnt      <= '0;
            i2c_ena      <= 1'b0;
            i2c_rw       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            error        <= 1'b0;
`ifdef SENSOR_READER_AVG4_EN
            acc          <= '0;
            avg_cnt      <= '0;
`endif
        end else begin
            sample_valid <= 1'b0;
            tmo_cnt      <= '0;

            if (in_wait && !edge_ok) begin
                if (tmo_hit) begin
                    error   <= 1'b1;
                    i2c_ena <= 1'b0;
                    state   <= ST_IDLE;
`ifdef SENSOR_READER_AVG4_EN
                    acc     <= '0;
                    avg_cnt <= '0;
`endif
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end

            case (state)
                ST_IDLE:      if (start_req) state <= ST_WAIT_FREE;
                ST_WAIT_FREE: if (edge_ok) begin
                                  i2c_ena <= 1'b1;
                                  i2c_rw  <= 1'b0;
                                  state   <= ST_PTR;
                              end
                ST_PTR:       if (edge_ok) begin
                                  i2c_rw <= 1'b1;
                                  state  <= ST_RD_MSB;
                              end
                ST_RD_MSB:    if (edge_ok) state <= ST_RD_LSB;
                // Master has latched the last read; dropping ena ends it with a stop.
                ST_RD_LSB:    if (edge_ok) begin
                                  i2c_ena <= 1'b0;
                                  state   <= ST_FINISH;
                              end
                ST_FINISH:    if (edge_ok) state <= ST_CHECK;
                // ack_error is sticky across the transaction, so judge it once here.
                ST_CHECK: begin
                    state <= ST_IDLE;
                    if (i2c_ack_error) begin
                        error <= 1'b1;
`ifdef SENSOR_READER_AVG4_EN
                        acc     <= '0;
                        avg_cnt <= '0;
`endif
                    end else begin
                        error <= 1'b0;
`ifdef SENSOR_READER_AVG4_EN
                        if (avg_cnt == 2'd3) begin
                            sample       <= acc_sum[17:2];
                            sample_valid <= 1'b1;
                            acc          <= '0;
                            avg_cnt      <= '0;
                        end else begin
                            acc     <= acc_sum;
                            avg_cnt <= avg_cnt + 1'b1;
                        end
`else
                        sample       <= {msb_q, lsb_q};
                        sample_valid <= 1'b1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_sensor_reader.sv
// -----------------------------------------------------------------------------
// tb_i2c_sensor_reader
// Drives i2c_sensor_reader with a command-level model of the i2c_master and an
// attached sensor (random byte times, gaps and data), and compares results
// against a transaction-level reference of the expected samples.
// -----------------------------------------------------------------------------
module tb_i2c_sensor_reader;

    localparam int PERIOD = 5000;
    localparam int TMO    = 200;

    localparam int EM_POST = 0;
    localparam int EM_IDLE = 1;
    localparam int EM_BYTE = 2;
    localparam int EM_GAP  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trigger = 1'b0;
    logic        auto_en = 1'b0;
    logic        i2c_ena;
    logic [6:0]  i2c_addr;
    logic        i2c_rw;
    logic [7:0]  i2c_data_wr;
    logic        i2c_busy = 1'b1;
    logic [7:0]  i2c_data_rd = 8'h00;
    logic        i2c_ack_error = 1'b0;
    logic [15:0] sample;
    logic        sample_valid;
    logic        error;
    logic        active;

    i2c_sensor_reader #(
        .PERIOD_CYCLES  (PERIOD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .trigger       (trigger),
        .auto_en       (auto_en),
        .i2c_ena       (i2c_ena),
        .i2c_addr      (i2c_addr),
        .i2c_rw        (i2c_rw),
        .i2c_data_wr   (i2c_data_wr),
        .i2c_busy      (i2c_busy),
        .i2c_data_rd   (i2c_data_rd),
        .i2c_ack_error (i2c_ack_error),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .error         (error),
        .active        (active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- master + sensor model ----------------
    int         em_st = EM_POST;
    int         em_cnt = 3;
    logic       em_rw = 1'b0;
    int         tr_cmds = 0;
    int         n_rstart = 0;
    int         n_starts = 0;
    int         start_cyc = 0;
    int         fall_cyc = 0;
    int         rd_idx = 0;
    logic [7:0] cmd0_data = 8'h00;
    logic       cmd0_rw = 1'b0;
    logic       cmd1_rw = 1'b0;
    logic       cmd2_rw = 1'b0;
    logic       addr_bad = 1'b0;
    logic [7:0] sl_b [2];
    bit         no_slave = 1'b0;
    bit         stuck_busy = 1'b1;

    task automatic em_latch();
        if (tr_cmds == 0) begin
            cmd0_rw   = i2c_rw;
            cmd0_data = i2c_data_wr;
        end else if (i2c_rw != em_rw) begin
            n_rstart++;
        end
        if (tr_cmds == 1) cmd1_rw = i2c_rw;
        if (tr_cmds == 2) cmd2_rw = i2c_rw;
        if (i2c_addr != 7'h40) addr_bad = 1'b1;
        if (no_slave || i2c_addr != 7'h40) i2c_ack_error = 1'b1;
        em_rw = i2c_rw;
        tr_cmds++;
        i2c_busy = 1'b1;
        em_st    = EM_BYTE;
        em_cnt   = $urandom_range(8, 30);
    endtask

    task automatic em_step();
        if (reset) begin
            em_st         = EM_POST;
            em_cnt        = 3;
            i2c_busy      = 1'b1;
            i2c_ack_error = 1'b0;
        end else begin
            case (em_st)
                EM_POST: begin
                    if (em_cnt == 0) begin
                        i2c_busy = stuck_busy;
                        em_st    = EM_IDLE;
                    end else em_cnt--;
                end
                EM_IDLE: begin
                    i2c_busy = stuck_busy;
                    if (!stuck_busy && i2c_ena) begin
                        n_starts++;
                        start_cyc     = cyc;
                        tr_cmds       = 0;
                        n_rstart      = 0;
                        rd_idx        = 0;
                        addr_bad      = 1'b0;
                        i2c_ack_error = 1'b0;
                        em_latch();
                    end
                end
                EM_BYTE: begin
                    if (em_cnt == 0) begin
                        if (em_rw) begin
                            i2c_data_rd = i2c_ack_error ? 8'hFF : ((rd_idx < 2) ? sl_b[rd_idx] : 8'hEE);
                            rd_idx++;
                        end
                        i2c_busy = 1'b0;
                        if (i2c_ena) begin
                            em_st  = EM_GAP;
                            em_cnt = $urandom_range(1, 3);
                        end else begin
                            em_st    = EM_IDLE;
                            fall_cyc = cyc;
                        end
                    end else em_cnt--;
                end
                EM_GAP: begin
                    if (em_cnt == 0) em_latch();
                    else em_cnt--;
                end
                default: em_st = EM_IDLE;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            em_step();
        end
    end

    // ---------------- output monitor ----------------
    int vld_cnt = 0;
    int vld_cyc = 0;
    bit ena_seen = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                vld_cnt++;
                vld_cyc = cyc;
            end
            if (i2c_ena) ena_seen = 1'b1;
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] m_sample = 16'h0000;
    bit          m_err = 1'b0;
    int          m_acc = 0;
    int          m_n = 0;

    task automatic model_fail();
        m_err = 1'b1;
        m_acc = 0;
        m_n   = 0;
    endtask

    task automatic model_read(input bit nack, input logic [15:0] v, output bit vld);
        vld = 1'b0;
        if (nack) begin
            model_fail();
        end else begin
            m_err = 1'b0;
`ifdef SENSOR_READER_AVG4_EN
            m_acc += int'(v);
            m_n++;
            if (m_n == 4) begin
                m_sample = 16'(m_acc / 4);
                vld      = 1'b1;
                m_acc    = 0;
                m_n      = 0;
            end
`else
            m_sample = v;
            vld      = 1'b1;
`endif
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (active && n < 3000) begin
            tick();
            n++;
        end
        check_val($sformatf("%s.done", tag), 32'(active), 32'd0);
    endtask

    task automatic chk_seq(input string tag);
        logic [19:0] got;
        got = {4'(tr_cmds), cmd0_rw, cmd1_rw, cmd2_rw, 4'(n_rstart), addr_bad, cmd0_data};
        check_val($sformatf("%s.cmdseq", tag), 32'(got), 32'({4'd3, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 8'h02}));
    endtask

    task automatic chk_result(input string tag, input int vld0, input bit exp_vld);
        check_val($sformatf("%s.vld", tag), 32'(vld_cnt - vld0), 32'(exp_vld));
        check_val($sformatf("%s.sample", tag), 32'(sample), 32'(m_sample));
        check_val($sformatf("%s.error", tag), 32'(error), 32'(m_err));
        if (exp_vld) check_val($sformatf("%s.latency", tag), 32'(vld_cyc - fall_cyc), 32'd3);
    endtask

    // One triggered read; drop_at>0 pulses a second trigger that many cycles in.
    task automatic do_read(input logic [7:0] b0, input logic [7:0] b1, input bit nack,
                           input int drop_at, input string tag);
        int  vld0;
        int  st0;
        bit  ev;
        sl_b[0]  = b0;
        sl_b[1]  = b1;
        no_slave = nack;
        vld0     = vld_cnt;
        st0      = n_starts;
        trigger  = 1'b1;
        tick();
        trigger  = 1'b0;
        if (drop_at > 0) begin
            repeat (drop_at) tick();
            trigger = 1'b1;
            tick();
            trigger = 1'b0;
        end
        wait_idle(tag);
        repeat (40) tick();
        model_read(nack, {b0, b1}, ev);
        check_val($sformatf("%s.starts", tag), 32'(n_starts - st0), 32'd1);
        chk_seq(tag);
        chk_result(tag, vld0, ev);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, active=%0b", active);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int st0;
        int vld0;
        int prev_start;
        bit ev;
        logic [7:0] b0;
        logic [7:0] b1;

        sl_b[0] = 8'h00;
        sl_b[1] = 8'h00;
        repeat (3) tick();
        check_val("rst.ena", 32'(i2c_ena), 32'd0);
        check_val("rst.rw", 32'(i2c_rw), 32'd0);
        check_val("rst.sample", 32'(sample), 32'd0);
        check_val("rst.valid", 32'(sample_valid), 32'd0);
        check_val("rst.error", 32'(error), 32'd0);
        check_val("rst.active", 32'(active), 32'd0);
        check_val("rst.addr", 32'(i2c_addr), 32'h40);
        reset = 1'b0;
        tick();

        // busy stuck high: timeout out of WAIT_FREE, ena never raised
        ena_seen = 1'b0;
        trigger  = 1'b1;
        tick();
        trigger  = 1'b0;
        n = 0;
        while (!error && n < TMO + 50) begin
            tick();
            n++;
        end
        check_val("tmo.cycles", 32'(n), 32'(TMO + 1));
        check_val("tmo.error", 32'(error), 32'd1);
        check_val("tmo.ena", 32'(ena_seen), 32'd0);
        check_val("tmo.active", 32'(active), 32'd0);
        model_fail();
        stuck_busy = 1'b0;
        repeat (5) tick();

        // directed values 100, 200, 300, 400
        do_read(8'h00, 8'h64, 1'b0, 0, "d100");
        do_read(8'h00, 8'hC8, 1'b0, 0, "d200");
        do_read(8'h01, 8'h2C, 1'b0, 0, "d300");
        do_read(8'h01, 8'h90, 1'b0, 0, "d400");
        do_read(8'h12, 8'h34, 1'b0, 0, "d1234");
        do_read(8'h56, 8'h78, 1'b1, 0, "nack");

        for (int i = 0; i < 10; i++) begin
            b0 = 8'($urandom_range(1, 255));
            b1 = 8'($urandom_range(0, 255));
            do_read(b0, b1, ($urandom_range(0, 3) == 0), 0, $sformatf("rnd%0d", i));
        end

        // trigger while busy is dropped
        do_read(8'hA5, 8'h5A, 1'b0, 12, "drop");

        // periodic reads with a dropped trigger in each
        auto_en    = 1'b1;
        prev_start = 0;
        for (int k = 0; k < 3; k++) begin
            sl_b[0]  = 8'($urandom_range(1, 255));
            sl_b[1]  = 8'($urandom_range(0, 255));
            no_slave = 1'b0;
            st0      = n_starts;
            vld0     = vld_cnt;
            n = 0;
            while (n_starts == st0 && n < PERIOD + 100) begin
                tick();
                n++;
            end
            check_val($sformatf("auto%0d.start", k), 32'(n_starts - st0), 32'd1);
            if (k > 0) check_val($sformatf("auto%0d.period", k), 32'(start_cyc - prev_start), 32'(PERIOD));
            prev_start = start_cyc;
            repeat (10) tick();
            trigger = 1'b1;
            tick();
            trigger = 1'b0;
            wait_idle($sformatf("auto%0d", k));
            model_read(1'b0, {sl_b[0], sl_b[1]}, ev);
            chk_seq($sformatf("auto%0d", k));
            chk_result($sformatf("auto%0d", k), vld0, ev);
        end
        auto_en = 1'b0;
        repeat (20) tick();

        // reset while reading the second byte
        sl_b[0]  = 8'hC3;
        sl_b[1]  = 8'h3C;
        st0      = n_starts;
        trigger  = 1'b1;
        tick();
        trigger  = 1'b0;
        n = 0;
        while (!(n_starts == st0 + 1 && tr_cmds == 2) && n < 500) begin
            tick();
            n++;
        end
        check_val("rstmid.reach", 32'(tr_cmds), 32'd2);
        repeat (3) tick();
        #3;
        reset = 1'b1;
        #1;
        check_val("rstmid.ena", 32'(i2c_ena), 32'd0);
        check_val("rstmid.active", 32'(active), 32'd0);
        check_val("rstmid.sample", 32'(sample), 32'd0);
        check_val("rstmid.valid", 32'(sample_valid), 32'd0);
        check_val("rstmid.error", 32'(error), 32'd0);
        m_sample = 16'h0000;
        m_err    = 1'b0;
        m_acc    = 0;
        m_n      = 0;
        repeat (2) tick();
        reset = 1'b0;
        do_read(8'h9E, 8'h21, 1'b0, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
